// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS-style control FSM (fetch/decode/execute/memory/writeback).
// Mealy terms in FETCH and MEM_WRITE are gated by mem_ready, which is masked while rst_n is low.
module multicycle_control #(
  parameter int OP_WIDTH    = 6,
  parameter int ALUOP_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OP_WIDTH-1:0]    opcode,
  input  logic                   mem_ready,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   MemtoReg,
  output logic                   IRWrite,
  output logic                   ALUSrcA,
  output logic                   RegWrite,
  output logic                   RegDst,
  output logic                   instr_done,
  output logic                   illegal_op,
  output logic [1:0]             PCSource,
  output logic [1:0]             ALUSrcB,
  output logic [ALUOP_WIDTH-1:0] ALUOp,
  output logic [3:0]             state
);
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3,
                         S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXECUTE = 4'd6, S_R_WB = 4'd7,
                         S_BRANCH = 4'd8, S_JUMP = 4'd9;
  localparam logic [OP_WIDTH-1:0] OP_R   = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_LW  = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW  = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OP_BEQ = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_J   = OP_WIDTH'(6'b000010);
  logic [3:0] r_state, w_next;
  logic       w_ready;
  assign w_ready = mem_ready & rst_n;
  assign state   = r_state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:     w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE:    w_next = (opcode == OP_R)                     ? S_EXECUTE  :
                            (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                            (opcode == OP_BEQ)                   ? S_BRANCH   :
                            (opcode == OP_J)                     ? S_JUMP     : S_FETCH;
      S_MEM_ADDR:  w_next = (opcode == OP_LW) ? S_MEM_READ : (opcode == OP_SW) ? S_MEM_WRITE : S_FETCH;
      S_MEM_READ:  w_next = w_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: w_next = w_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   w_next = S_R_WB;
      default:     w_next = S_FETCH;
    endcase
  end
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = '0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = w_ready;
        PCWrite = w_ready;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = !(opcode == OP_R || opcode == OP_LW || opcode == OP_SW ||
                       opcode == OP_BEQ || opcode == OP_J);
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = w_ready;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_WIDTH'(2'b10);
      end
      S_R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_WIDTH'(2'b01);
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed cycle-by-cycle vectors for multicycle_control.
module tb_multicycle_control;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_BAD = 6'b111111;
  logic       clk = 1'b0, rst_n, mem_ready;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA;
  logic       RegWrite, RegDst, instr_done, illegal_op;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] state;
  int         n_checks = 0, n_fail = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .instr_done(instr_done), .illegal_op(illegal_op),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive inputs just after the falling edge; outputs settle 1 time unit later.
  task automatic cyc(input logic mr, input logic [5:0] op);
    @(negedge clk);
    mem_ready = mr;
    opcode    = op;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_R;
    #3;
    check("rst_state", state, 0);
    check("rst_pcwrite", PCWrite, 0);
    check("rst_irwrite", IRWrite, 0);
    check("rst_memread", MemRead, 1);
    check("rst_alusrcb", ALUSrcB, 2'b01);
    check("rst_done", instr_done, 0);
    #20;
    check("rst_hold_state", state, 0);
    // R-type
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; opcode = OP_R; #1;
    check("r_s0", state, 0);
    check("r_pcwrite", PCWrite, 1);
    check("r_irwrite", IRWrite, 1);
    cyc(1, OP_R);
    check("r_s1", state, 1);
    check("r_dec_alusrcb", ALUSrcB, 2'b11);
    check("r_dec_illegal", illegal_op, 0);
    cyc(1, OP_R);
    check("r_s6", state, 6);
    check("r_aluop", ALUOp, 2'b10);
    check("r_alusrca", ALUSrcA, 1);
    cyc(1, OP_R);
    check("r_s7", state, 7);
    check("r_regwrite", RegWrite, 1);
    check("r_regdst", RegDst, 1);
    check("r_done", instr_done, 1);
    // lw with two wait cycles; opcode scrambled inside MEM_READ must be ignored
    cyc(1, OP_LW);
    check("lw_s0", state, 0);
    cyc(1, OP_LW);
    check("lw_s1", state, 1);
    cyc(0, OP_LW);
    check("lw_s2", state, 2);
    check("lw_alusrcb", ALUSrcB, 2'b10);
    cyc(0, OP_BAD);
    check("lw_s3a", state, 3);
    check("lw_memread_a", MemRead, 1);
    check("lw_iord_a", IorD, 1);
    cyc(0, OP_BAD);
    check("lw_s3b", state, 3);
    check("lw_iord_b", IorD, 1);
    cyc(1, OP_BAD);
    check("lw_s3c", state, 3);
    check("lw_memread_c", MemRead, 1);
    cyc(1, OP_R);
    check("lw_s4", state, 4);
    check("lw_memtoreg", MemtoReg, 1);
    check("lw_regwrite", RegWrite, 1);
    check("lw_regdst", RegDst, 0);
    // beq then j
    cyc(1, OP_BEQ);
    check("beq_s0", state, 0);
    cyc(1, OP_BEQ);
    check("beq_s1", state, 1);
    cyc(1, OP_BEQ);
    check("beq_s8", state, 8);
    check("beq_aluop", ALUOp, 2'b01);
    check("beq_pcwc", PCWriteCond, 1);
    check("beq_pcsrc", PCSource, 2'b01);
    check("beq_pcwrite", PCWrite, 0);
    cyc(1, OP_J);
    check("j_s0", state, 0);
    cyc(1, OP_J);
    check("j_s1", state, 1);
    cyc(1, OP_J);
    check("j_s9", state, 9);
    check("j_pcwrite", PCWrite, 1);
    check("j_pcsrc", PCSource, 2'b10);
    check("j_done", instr_done, 1);
    // illegal opcode
    cyc(1, OP_BAD);
    check("ill_s0", state, 0);
    cyc(1, OP_BAD);
    check("ill_s1", state, 1);
    check("ill_flag", illegal_op, 1);
    check("ill_regwrite", RegWrite, 0);
    check("ill_memwrite", MemWrite, 0);
    check("ill_pcwc", PCWriteCond, 0);
    // fetch stall, three cycles
    cyc(0, OP_SW);
    check("ill_back_s0", state, 0);
    check("ill_flag_clr", illegal_op, 0);
    check("stall1_pcwrite", PCWrite, 0);
    check("stall1_irwrite", IRWrite, 0);
    cyc(0, OP_SW);
    check("stall2_state", state, 0);
    check("stall2_pcwrite", PCWrite, 0);
    cyc(0, OP_SW);
    check("stall3_state", state, 0);
    check("stall3_irwrite", IRWrite, 0);
    cyc(1, OP_SW);
    check("stall_go_pcwrite", PCWrite, 1);
    check("stall_go_irwrite", IRWrite, 1);
    // sw, then asynchronous reset while waiting in MEM_WRITE
    cyc(1, OP_SW);
    check("sw_s1", state, 1);
    cyc(0, OP_SW);
    check("sw_s2", state, 2);
    cyc(0, OP_SW);
    check("sw_s5", state, 5);
    check("sw_memwrite", MemWrite, 1);
    check("sw_iord", IorD, 1);
    check("sw_done_wait", instr_done, 0);
    mem_ready = 1'b1; #1;
    check("sw_done_ready", instr_done, 1);
    mem_ready = 1'b0; #1;
    rst_n = 1'b0; #1;
    check("arst_state", state, 0);
    check("arst_memwrite", MemWrite, 0);
    check("arst_memread", MemRead, 1);
    mem_ready = 1'b1; #1;
    check("arst_pcwrite_masked", PCWrite, 0);
    check("arst_irwrite_masked", IRWrite, 0);
    @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; opcode = OP_R; #1;
    check("rel_s0", state, 0);
    check("rel_pcwrite", PCWrite, 1);
    cyc(1, OP_R);
    check("rel_s1", state, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected end before 50000");
    $fatal(1, "timeout");
  end
endmodule
